io_bridge: RTL

- Memory-mapped peripheral block directly downstream of the CPU datapath.
- Consumes the CPU's 16-bit address output and its bidirectional data bus, and drives the bus for reads.
- Provides 2 output port registers, 2 synchronized input ports, and a down-counting timer with prescaler and expiry flag.
- All accesses complete in one clock, so no stall handshake with the single-cycle CPU is needed.

---
 rtl/io_bridge_pkg.sv | 25 ++
 rtl/io_timer.sv | 105 ++++++++++
 rtl/io_bridge.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/io_bridge_pkg.sv
// Shared constants for the io_bridge peripheral: register offsets, CTRL/STATUS
// bit positions and the timer state encoding.
package io_bridge_pkg;

  localparam logic [2:0] OFF_OUT0   = 3'd0;
  localparam logic [2:0] OFF_OUT1   = 3'd1;
  localparam logic [2:0] OFF_IN0    = 3'd2;
  localparam logic [2:0] OFF_IN1    = 3'd3;
  localparam logic [2:0] OFF_CTRL   = 3'd4;
  localparam logic [2:0] OFF_LOAD   = 3'd5;
  localparam logic [2:0] OFF_COUNT  = 3'd6;
  localparam logic [2:0] OFF_STATUS = 3'd7;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int CTRL_IE   = 2;

  localparam int ST_EXP = 0;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/io_timer.sv
// Down-counting timer for io_bridge: prescaler, COUNT/LOAD registers, sticky
// expiry flag and the one-shot EN auto-clear request (en_clr).
module io_timer
  import io_bridge_pkg::*;
#(
  parameter int PRESC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        auto_en,
  input  logic        ctrl_we,
  input  logic        ctrl_en,
  input  logic        load_we,
  input  logic [15:0] load_wdata,
  input  logic        exp_clr,
  output logic [15:0] count,
  output logic [15:0] load,
  output logic        exp,
  output logic        en_clr,
  output logic        state
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESC - 1);

  timer_state_e  state_cur;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   count_q, count_d;
  logic [15:0]   load_q, load_d;
  logic          exp_q, exp_d;
  logic          tick;
  logic          expire;

  always_comb begin
    state_cur = en ? T_RUN : T_IDLE;
    tick      = (state_cur == T_RUN) && (presc_q == P_LAST);
    expire    = tick && (count_q == 16'd0);
  end

  always_comb begin
    presc_d = presc_q;
    count_d = count_q;
    load_d  = load_q;
    exp_d   = exp_q;
    en_clr  = 1'b0;

    if (state_cur == T_RUN) begin
      if (tick) begin
        presc_d = '0;
        if (count_q != 16'd0) begin
          count_d = count_q - 16'd1;
        end else if (auto_en) begin
          count_d = load_q;
        end else begin
          en_clr = 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else begin
      presc_d = '0;
    end

    // A write disabling the timer parks the prescaler so the next enable starts at 0.
    if (ctrl_we && !ctrl_en) begin
      presc_d = '0;
    end

    if (load_we) begin
      load_d = load_wdata;
      if (state_cur == T_IDLE) begin
        count_d = load_wdata;
      end
    end

    // Set beats clear when an expiry lands on the same edge as a STATUS read.
    if (exp_clr) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      count_q <= '0;
      load_q  <= '0;
      exp_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      load_q  <= load_d;
      exp_q   <= exp_d;
    end
  end

  assign count = count_q;
  assign load  = load_q;
  assign exp   = exp_q;
  assign state = state_cur;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped I/O bridge: two output ports, two synchronized inputs and a
// prescaled timer. Define IO_BRIDGE_IRQ_EN to enable CTRL.IE and the irq output.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'hFF00,
  parameter int          PRESC = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] direcciones,
  inout  wire  [15:0] datos,
  input  logic        oe,
  input  logic        rd,
  input  logic [15:0] in0,
  input  logic [15:0] in1,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic        irq
);

  logic        sel;
  logic [2:0]  off;
  logic        wr_en;
  logic        rd_en;
  logic        ctrl_we;
  logic        load_we;
  logic        exp_clr;
  logic [15:0] rdata;

  logic [15:0] out0_q, out0_d;
  logic [15:0] out1_q, out1_d;
  logic        en_q, en_d;
  logic        auto_q, auto_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;
  logic [15:0] in0_s1_q, in0_s2_q;
  logic [15:0] in1_s1_q, in1_s2_q;

  logic [15:0] t_count;
  logic [15:0] t_load;
  logic        t_exp;
  logic        t_en_clr;
  logic        t_state;

  always_comb begin
    sel     = (direcciones[15:3] == BASE[15:3]);
    off     = direcciones[2:0];
    wr_en   = sel && oe;
    rd_en   = sel && !oe && rd;
    ctrl_we = wr_en && (off == OFF_CTRL);
    load_we = wr_en && (off == OFF_LOAD);
    exp_clr = rd_en && (off == OFF_STATUS);
  end

  io_timer #(
    .PRESC(PRESC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .en         (en_q),
    .auto_en    (auto_q),
    .ctrl_we    (ctrl_we),
    .ctrl_en    (datos[CTRL_EN]),
    .load_we    (load_we),
    .load_wdata (datos),
    .exp_clr    (exp_clr),
    .count      (t_count),
    .load       (t_load),
    .exp        (t_exp),
    .en_clr     (t_en_clr),
    .state      (t_state)
  );

  always_comb begin
    out0_d = out0_q;
    out1_d = out1_q;
    en_d   = en_q;
    auto_d = auto_q;
    ie_d   = ie_q;

    if (wr_en && (off == OFF_OUT0)) begin
      out0_d = datos;
    end
    if (wr_en && (off == OFF_OUT1)) begin
      out1_d = datos;
    end

    // A CTRL write on the expiry edge overrides the one-shot auto-clear.
    if (t_en_clr) begin
      en_d = 1'b0;
    end
    if (ctrl_we) begin
      en_d   = datos[CTRL_EN];
      auto_d = datos[CTRL_AUTO];
`ifdef IO_BRIDGE_IRQ_EN
      ie_d   = datos[CTRL_IE];
`endif
    end
`ifndef IO_BRIDGE_IRQ_EN
    ie_d = 1'b0;
`endif

    irq_d = t_exp && ie_q;
  end

  always_comb begin
    rdata = 16'h0000;
    case (off)
      OFF_OUT0:   rdata = out0_q;
      OFF_OUT1:   rdata = out1_q;
      OFF_IN0:    rdata = in0_s2_q;
      OFF_IN1:    rdata = in1_s2_q;
      OFF_CTRL:   rdata = {13'd0, ie_q, auto_q, (t_state == T_RUN)};
      OFF_LOAD:   rdata = t_load;
      OFF_COUNT:  rdata = t_count;
      OFF_STATUS: rdata = {15'd0, t_exp};
      default:    rdata = 16'h0000;
    endcase
  end

  assign datos = rd_en ? rdata : 16'hzzzz;

  always_ff @(posedge clk) begin
    if (reset) begin
      out0_q   <= '0;
      out1_q   <= '0;
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      ie_q     <= 1'b0;
      irq_q    <= 1'b0;
      in0_s1_q <= '0;
      in0_s2_q <= '0;
      in1_s1_q <= '0;
      in1_s2_q <= '0;
    end else begin
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      en_q     <= en_d;
      auto_q   <= auto_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      in0_s1_q <= in0;
      in0_s2_q <= in0_s1_q;
      in1_s1_q <= in1;
      in1_s2_q <= in1_s1_q;
    end
  end

  assign out0 = out0_q;
  assign out1 = out1_q;
  assign irq  = irq_q;

endmodule
